// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared encodings for the execute stage and EX/MEM latch
package pipeline_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   // ALU_ZERO forces a zero result for unsupported funct codes
   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_AND  = 3'd2;
   localparam logic [2:0] ALU_OR   = 3'd3;
   localparam logic [2:0] ALU_SLT  = 3'd4;
   localparam logic [2:0] ALU_ZERO = 3'd5;

   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   localparam int M_BRANCH   = 2;
   localparam int M_MEMREAD  = 1;
   localparam int M_MEMWRITE = 0;

   localparam int EX_REGDST   = 3;
   localparam int EX_ALUOP_HI = 2;
   localparam int EX_ALUOP_LO = 1;
   localparam int EX_ALUSRC   = 0;

endpackage

// File: rtl/alu_ctl_alu.sv
// rtl/alu_ctl_alu.sv - ALU control decode and ALU with zero flag
module alu_ctl_alu
   import pipeline_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [1:0]    aluop,
   input  logic [5:0]    funct,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] result,
   output logic          zero
);

   logic [2:0] op;

   always_comb begin
      op = ALU_ZERO;
      case (aluop)
         ALUOP_ADD: op = ALU_ADD;
         ALUOP_SUB: op = ALU_SUB;
         default: begin
            // aluop 10 and 11 both select funct decode
            case (funct)
               FUNCT_ADD: op = ALU_ADD;
               FUNCT_SUB: op = ALU_SUB;
               FUNCT_AND: op = ALU_AND;
               FUNCT_OR:  op = ALU_OR;
               FUNCT_SLT: op = ALU_SLT;
               default:   op = ALU_ZERO;
            endcase
         end
      endcase
   end

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_SLT: result = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - execute stage with EX/MEM latch, stall and flush
module ex_mem_stage
   import pipeline_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall,
   input  logic          flush,
   input  logic [1:0]    wb_ctl,
   input  logic [2:0]    m_ctl,
   input  logic [3:0]    ex_ctl,
   input  logic [DW-1:0] npc,
   input  logic [DW-1:0] rdata1,
   input  logic [DW-1:0] rdata2,
   input  logic [DW-1:0] s_extend,
   input  logic [RW-1:0] instr_2016,
   input  logic [RW-1:0] instr_1511,
   output logic [1:0]    wb_ctlout,
   output logic          branch,
   output logic          memread,
   output logic          memwrite,
   output logic [DW-1:0] add_result,
   output logic          zero,
   output logic [DW-1:0] alu_result,
   output logic [DW-1:0] rdata2out,
   output logic [RW-1:0] five_bit_muxout,
   output logic          valid
);

   logic [DW-1:0] alu_b;
   logic [DW-1:0] ex_result;
   logic          ex_zero;
   logic [DW-1:0] ex_target;
   logic [RW-1:0] ex_dest;

   assign alu_b     = ex_ctl[EX_ALUSRC] ? s_extend : rdata2;
   assign ex_target = npc + (s_extend << 2);
   assign ex_dest   = ex_ctl[EX_REGDST] ? instr_1511 : instr_2016;

   alu_ctl_alu #(.DW(DW)) u_alu (
      .aluop  (ex_ctl[EX_ALUOP_HI:EX_ALUOP_LO]),
      .funct  (s_extend[5:0]),
      .a      (rdata1),
      .b      (alu_b),
      .result (ex_result),
      .zero   (ex_zero)
   );

   logic [1:0]    wb_ctl_q,     wb_ctl_d;
   logic [2:0]    m_ctl_q,      m_ctl_d;
   logic [DW-1:0] add_result_q, add_result_d;
   logic          zero_q,       zero_d;
   logic [DW-1:0] alu_result_q, alu_result_d;
   logic [DW-1:0] rdata2_q,     rdata2_d;
   logic [RW-1:0] dest_q,       dest_d;
   logic          valid_q,      valid_d;

   always_comb begin
      wb_ctl_d     = wb_ctl_q;
      m_ctl_d      = m_ctl_q;
      add_result_d = add_result_q;
      zero_d       = zero_q;
      alu_result_d = alu_result_q;
      rdata2_d     = rdata2_q;
      dest_d       = dest_q;
      valid_d      = valid_q;
      if (flush || !stall) begin
         add_result_d = ex_target;
         zero_d       = ex_zero;
         alu_result_d = ex_result;
         rdata2_d     = rdata2;
         dest_d       = ex_dest;
         // flush overrides stall: control is bubbled, datapath still loads
         if (flush) begin
            wb_ctl_d = '0;
            m_ctl_d  = '0;
            valid_d  = 1'b0;
         end else begin
            wb_ctl_d = wb_ctl;
            m_ctl_d  = m_ctl;
            valid_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_ctl_q     <= '0;
         m_ctl_q      <= '0;
         add_result_q <= '0;
         zero_q       <= 1'b0;
         alu_result_q <= '0;
         rdata2_q     <= '0;
         dest_q       <= '0;
         valid_q      <= 1'b0;
      end else begin
         wb_ctl_q     <= wb_ctl_d;
         m_ctl_q      <= m_ctl_d;
         add_result_q <= add_result_d;
         zero_q       <= zero_d;
         alu_result_q <= alu_result_d;
         rdata2_q     <= rdata2_d;
         dest_q       <= dest_d;
         valid_q      <= valid_d;
      end
   end

   assign wb_ctlout       = wb_ctl_q;
   assign branch          = m_ctl_q[M_BRANCH];
   assign memread         = m_ctl_q[M_MEMREAD];
   assign memwrite        = m_ctl_q[M_MEMWRITE];
   assign add_result      = add_result_q;
   assign zero            = zero_q;
   assign alu_result      = alu_result_q;
   assign rdata2out       = rdata2_q;
   assign five_bit_muxout = dest_q;
   assign valid           = valid_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed self-checking bench for ex_mem_stage
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n, stall, flush;
   logic [1:0]  wb_ctl;
   logic [2:0]  m_ctl;
   logic [3:0]  ex_ctl;
   logic [31:0] npc, rdata1, rdata2, s_extend;
   logic [4:0]  instr_2016, instr_1511;
   logic [1:0]  wb_ctlout;
   logic        branch, memread, memwrite, zero, valid;
   logic [31:0] add_result, alu_result, rdata2out;
   logic [4:0]  five_bit_muxout;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   ex_mem_stage #(.DW(32), .RW(5)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .wb_ctl(wb_ctl), .m_ctl(m_ctl), .ex_ctl(ex_ctl), .npc(npc),
      .rdata1(rdata1), .rdata2(rdata2), .s_extend(s_extend),
      .instr_2016(instr_2016), .instr_1511(instr_1511),
      .wb_ctlout(wb_ctlout), .branch(branch), .memread(memread), .memwrite(memwrite),
      .add_result(add_result), .zero(zero), .alu_result(alu_result),
      .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout), .valid(valid)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] w, input logic [2:0] m, input logic [3:0] e,
                        input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] se, input logic [4:0] rt, input logic [4:0] rd);
      wb_ctl = w; m_ctl = m; ex_ctl = e; npc = pc;
      rdata1 = r1; rdata2 = r2; s_extend = se; instr_2016 = rt; instr_1511 = rd;
   endtask

   task automatic check_all(input string tag, input logic [1:0] w, input logic b, input logic mr,
                            input logic mw, input logic [31:0] ar, input logic z,
                            input logic [31:0] alu, input logic [31:0] r2o,
                            input logic [4:0] dst, input logic v);
      check({tag, ".wb"},       32'(wb_ctlout), 32'(w));
      check({tag, ".branch"},   32'(branch), 32'(b));
      check({tag, ".memread"},  32'(memread), 32'(mr));
      check({tag, ".memwrite"}, 32'(memwrite), 32'(mw));
      check({tag, ".add"},      add_result, ar);
      check({tag, ".zero"},     32'(zero), 32'(z));
      check({tag, ".alu"},      alu_result, alu);
      check({tag, ".rdata2"},   rdata2out, r2o);
      check({tag, ".dest"},     32'(five_bit_muxout), 32'(dst));
      check({tag, ".valid"},    32'(valid), 32'(v));
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      // R-type add: npc 0x40 -> target 0x40 + (0x20<<2) = 0xC0
      drive(2'b01, 3'b010, 4'b1100, 32'h40, 32'd5, 32'd6, 32'h20, 5'd8, 5'd9);
      tick();
      tick();
      check_all("reset", 2'b00, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0, 0);

      rst_n = 1'b1;
      tick();
      check_all("radd", 2'b01, 0, 1, 0, 32'hC0, 0, 32'd11, 32'd6, 5'd9, 1);

      // lw/addi: 0x100 + 0xFFFFFFFC; target 0x100 + 0xFFFFFFF0 = 0xF0
      drive(2'b11, 3'b010, 4'b0001, 32'h100, 32'h100, 32'h55, 32'hFFFFFFFC, 5'd8, 5'd9);
      tick();
      check_all("lw", 2'b11, 0, 1, 0, 32'hF0, 0, 32'hFC, 32'h55, 5'd8, 1);

      drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd1, 5'd2);
      tick();
      check("slt_neg.alu", alu_result, 32'd1);
      check("slt_neg.zero", 32'(zero), 32'd0);

      drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h2A, 5'd1, 5'd2);
      tick();
      check("slt_pos.alu", alu_result, 32'd0);
      check("slt_pos.zero", 32'(zero), 32'd1);

      drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'd10, 32'd3, 32'h22, 5'd1, 5'd2);
      tick();
      check("rsub.alu", alu_result, 32'd7);

      drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'hC, 32'hA, 32'h24, 5'd1, 5'd2);
      tick();
      check("rand.alu", alu_result, 32'd8);

      drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'hC, 32'hA, 32'h25, 5'd1, 5'd2);
      tick();
      check("ror.alu", alu_result, 32'hE);

      drive(2'b10, 3'b000, 4'b1100, 32'h0, 32'd5, 32'd6, 32'h0, 5'd1, 5'd2);
      tick();
      check("badfunct.alu", alu_result, 32'd0);
      check("badfunct.zero", 32'(zero), 32'd1);

      drive(2'b10, 3'b000, 4'b1110, 32'h0, 32'd5, 32'd6, 32'h20, 5'd1, 5'd2);
      tick();
      check("aluop11.alu", alu_result, 32'd11);

      // beq: target 4 + (3<<2) = 16
      drive(2'b00, 3'b100, 4'b0010, 32'd4, 32'd7, 32'd7, 32'd3, 5'd3, 5'd4);
      tick();
      check_all("beq", 2'b00, 1, 0, 0, 32'd16, 1, 32'd0, 32'd7, 5'd3, 1);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(2'b01, 3'b011, 4'b1100, 32'h40 + 32'(i), 32'd5, 32'd6 + 32'(i), 32'h20, 5'd8, 5'd9);
         tick();
         check_all("stall", 2'b00, 1, 0, 0, 32'd16, 1, 32'd0, 32'd7, 5'd3, 1);
      end

      flush = 1'b1;
      drive(2'b01, 3'b011, 4'b1100, 32'h40, 32'd5, 32'd6, 32'h20, 5'd8, 5'd9);
      tick();
      check_all("flush", 2'b00, 0, 0, 0, 32'hC0, 0, 32'd11, 32'd6, 5'd9, 0);
      flush = 1'b0;
      stall = 1'b0;

      drive(2'b01, 3'b001, 4'b0000, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'd1, 32'd1, 5'd6, 5'd7);
      tick();
      check_all("wrap", 2'b01, 0, 0, 1, 32'h0, 1, 32'h0, 32'd1, 5'd6, 1);

      rst_n = 1'b0;
      tick();
      check_all("midreset", 2'b00, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 5'd0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Consumer end of the ID/EX pipeline latch: the execute stage plus the EX/MEM latch of the 5-stage MIPS pipeline.
- Takes the registered ID/EX bundle (control fields, npc, operands, sign-extended immediate, rt/rd fields).
- Performs ALU control decode, the ALU operation, branch-target add and destination-register select.
- Registers all results into the EX/MEM latch, with stall (hold) and flush (bubble) support.

Parameters:
- DW, 32, datapath width
- RW, 5, register-specifier width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- stall  in  1  hold EX/MEM latch contents
- flush  in  1  load a bubble (control fields zeroed)
- wb_ctl  in  2  {regwrite, memtoreg}
- m_ctl  in  3  {branch, memread, memwrite}
- ex_ctl  in  4  {regdst, aluop[1:0], alusrc}
- npc  in  DW  PC+4 of the instruction
- rdata1  in  DW  rs operand
- rdata2  in  DW  rt operand
- s_extend  in  DW  sign-extended immediate; bits [5:0] are funct
- instr_2016  in  RW  rt field
- instr_1511  in  RW  rd field
- wb_ctlout  out  2  latched wb_ctl
- branch  out  1  latched m_ctl[2]
- memread  out  1  latched m_ctl[1]
- memwrite  out  1  latched m_ctl[0]
- add_result  out  DW  latched branch target
- zero  out  1  latched ALU zero flag
- alu_result  out  DW  latched ALU result
- rdata2out  out  DW  latched rt operand (store data)
- five_bit_muxout  out  RW  latched destination register
- valid  out  1  latched entry holds a real instruction (not a bubble)

Behaviour:
- Reset: when rst_n=0 at a rising edge, every output register is cleared to 0 on that edge (valid=0). Reset overrides stall and flush. Reset asserted mid-operation discards the latched entry.
- Latency: one cycle. Inputs sampled at edge N appear on the outputs after edge N; the combinational EX logic sits in front of the latch.
- Priority at each edge: reset > flush > stall > load.
- flush=1: wb_ctlout, branch, memread, memwrite and valid are cleared to 0. Datapath registers load normally; their values are don't-care, but the bench expects the normal load. Flush together with stall is treated as flush.
- stall=1 (no flush): all registers hold their values.
- Load: all registers capture the EX results; valid is set to 1.
- ALU B operand: s_extend if alusrc=1, else rdata2.
- ALU control, aluop:
  - 00: add.
  - 01: sub.
  - 10 and 11: decode funct = s_extend[5:0]:
    - 100000 add
    - 100010 sub
    - 100100 and
    - 100101 or
    - 101010 slt (signed compare, result 1 or 0)
    - any other funct: result 0.
- Arithmetic: modulo 2^DW, overflow ignored, no exception.
- zero = (ALU result == 0), computed before the latch.
- add_result = npc + (s_extend << 2), modulo 2^DW.
- five_bit_muxout = instr_1511 if regdst=1, else instr_2016.
- rdata2out always carries rdata2, regardless of alusrc.
- No X propagation: every output is defined after the first edge with rst_n=0.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - ALUOp encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_RTYPE=10)
  - funct constants
  - internal 3-bit ALU operation codes
  - control-field bit positions for wb/m/ex
- One sub-module is natural: alu_ctl_alu, combining ALU control decode and ALU, with outputs result and zero. Branch adder, regdst mux and the latch stay in ex_mem_stage.

Test Plan:
1. Reset: hold rst_n=0 for 2 edges while applying nonzero inputs -> all outputs 0 and valid=0. Release rst_n -> the next edge loads the inputs.
2. R-type add: ex_ctl=1100, rdata1=5, rdata2=6, s_extend=0x20, rt=8, rd=9, wb_ctl=1, m_ctl=2 -> after one edge: alu_result=11, zero=0, five_bit_muxout=9, wb_ctlout=1, memread=1, valid=1.
3. lw/addi path: ex_ctl=0001, rdata1=0x100, s_extend=0xFFFFFFFC -> alu_result=0xFC, five_bit_muxout=rt. Then slt with rdata1=-1, rdata2=1, funct=101010 -> alu_result=1.
4. beq: ex_ctl=0010, m_ctl=100, rdata1=rdata2=7, npc=4, s_extend=3 -> zero=1, add_result=16, branch=1.
5. Stall and flush: load an entry, then assert stall for 3 edges while changing inputs -> outputs unchanged. Then assert flush+stall together -> wb_ctlout, branch, memread, memwrite and valid become 0.
6. Wrap-around: rdata1=0xFFFFFFFF, rdata2=1, add -> alu_result=0, zero=1. Also npc=0xFFFFFFFC, s_extend=1 -> add_result=0.
